// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter
//
// Two-master Wishbone arbiter. The CPU instruction-fetch master ("if") and
// the data-memory master ("mem") share one Wishbone slave bus. A master owns
// the bus for a whole transaction, from the rise of its cyc to the fall of
// its cyc. A watchdog raises a sticky flag when a granted strobe waits too
// long for an ack.
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, ties go to the master that did not
//                        win the previous grant. A 1-bit last-winner register
//                        tracks this and resets to "data". When undefined,
//                        the data master always wins a tie.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   if_wb_*_i        fetch-master request (cyc/stb/we/adr/dat/sel)
//   if_wb_ack_o      ack routed to the fetch master while it is granted
//   if_wb_dat_o      read data to the fetch master (always wb_dat_i)
//   mem_wb_*_i       data-master request (cyc/stb/we/adr/dat/sel)
//   mem_wb_ack_o     ack routed to the data master while it is granted
//   mem_wb_dat_o     read data to the data master (always wb_dat_i)
//   wb_*_o           shared-bus request, all zero when idle
//   wb_ack_i         slave ack
//   wb_dat_i         slave read data
//   grant_o          one-hot grant: bit0 fetch, bit1 data, 00 idle
//   timeout_o        sticky watchdog flag, cleared only by reset

module wb_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  // fetch master
  input  logic                    if_wb_cyc_i,
  input  logic                    if_wb_stb_i,
  input  logic                    if_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   if_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   if_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] if_wb_sel_i,
  output logic                    if_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   if_wb_dat_o,
  // data master
  input  logic                    mem_wb_cyc_i,
  input  logic                    mem_wb_stb_i,
  input  logic                    mem_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   mem_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] mem_wb_sel_i,
  output logic                    mem_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   mem_wb_dat_o,
  // shared bus
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic                    wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  // status
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  // The encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    GRANT_IF  = 2'b01,
    GRANT_MEM = 2'b10
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  state_t      tie_winner;
  logic        granted_cyc;
  logic        stalled;
  logic [15:0] wdog_count_reg;
  logic        timeout_reg;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_mem_reg;  // 1: data master won the most recent grant
  assign tie_winner = last_mem_reg ? GRANT_IF : GRANT_MEM;
`else
  assign tie_winner = GRANT_MEM;
`endif

  // Next-state decision. A grant holds while the owner's cyc stays high;
  // otherwise the idle rule is re-applied to the requests present now,
  // which gives a direct handoff with no idle cycle in between. The
  // releasing master's cyc is low, so it cannot win straight back.
  always_comb begin
    granted_cyc = 1'b0;
    case (state_reg)
      GRANT_IF:  granted_cyc = if_wb_cyc_i;
      GRANT_MEM: granted_cyc = mem_wb_cyc_i;
      default:   granted_cyc = 1'b0;
    endcase

    state_next = state_reg;
    if (!granted_cyc) begin
      if (if_wb_cyc_i && mem_wb_cyc_i) begin
        state_next = tie_winner;
      end else if (if_wb_cyc_i) begin
        state_next = GRANT_IF;
      end else if (mem_wb_cyc_i) begin
        state_next = GRANT_MEM;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Bus multiplexing is combinational from the state, so the ack path
  // adds no latency.
  always_comb begin
    wb_cyc_o     = 1'b0;
    wb_stb_o     = 1'b0;
    wb_we_o      = 1'b0;
    wb_adr_o     = '0;
    wb_dat_o     = '0;
    wb_sel_o     = '0;
    if_wb_ack_o  = 1'b0;
    mem_wb_ack_o = 1'b0;
    case (state_reg)
      GRANT_IF: begin
        wb_cyc_o    = if_wb_cyc_i;
        wb_stb_o    = if_wb_stb_i;
        wb_we_o     = if_wb_we_i;
        wb_adr_o    = if_wb_adr_i;
        wb_dat_o    = if_wb_dat_i;
        wb_sel_o    = if_wb_sel_i;
        if_wb_ack_o = wb_ack_i;
      end
      GRANT_MEM: begin
        wb_cyc_o     = mem_wb_cyc_i;
        wb_stb_o     = mem_wb_stb_i;
        wb_we_o      = mem_wb_we_i;
        wb_adr_o     = mem_wb_adr_i;
        wb_dat_o     = mem_wb_dat_i;
        wb_sel_o     = mem_wb_sel_i;
        mem_wb_ack_o = wb_ack_i;
      end
      default: begin
      end
    endcase
  end

  assign if_wb_dat_o  = wb_dat_i;
  assign mem_wb_dat_o = wb_dat_i;
  assign grant_o      = state_reg;
  assign timeout_o    = timeout_reg;

  // A granted strobe waiting for an ack.
  assign stalled = (state_reg != IDLE) && wb_stb_o && !wb_ack_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      wdog_count_reg <= '0;
      timeout_reg    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_reg   <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;

`ifdef ARB_ROUND_ROBIN_EN
      if ((state_next != state_reg) && (state_next != IDLE)) begin
        last_mem_reg <= (state_next == GRANT_MEM);
      end
`endif

      // The flag sets on the same edge the count reaches the limit; the
      // counter then saturates. Release is never forced.
      if (state_next != state_reg) begin
        wdog_count_reg <= '0;
      end else if (stalled) begin
        if (wdog_count_reg < TIMEOUT_LIMIT) begin
          wdog_count_reg <= wdog_count_reg + 16'd1;
        end
        if (wdog_count_reg >= TIMEOUT_LIMIT - 16'd1) begin
          timeout_reg <= 1'b1;
        end
      end else begin
        wdog_count_reg <= '0;
      end
    end
  end

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Two-master Wishbone arbiter sharing one Wishbone slave bus between the CPU instruction-fetch master and the data-memory master. It sits between the pipeline's two master interfaces and the single SRAM/peripheral bus. Each transaction is granted whole, from `cyc` rise to `cyc` fall. A watchdog flags a granted transfer that never receives `ack`.

## Interface
**Parameters**
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; `sel` is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 255: number of cycles with granted `stb` high and no `ack` before `timeout_o` sets. Range 1..65535.

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`, in, 1: clock.
  - `reset`, in, 1: asynchronous active-high reset.
- Fetch master port:
  - `if_wb_cyc_i`, `if_wb_stb_i`, `if_wb_we_i`, in, 1 each: fetch-master request.
  - `if_wb_adr_i`, in, ADDR_WIDTH; `if_wb_dat_i`, in, DATA_WIDTH; `if_wb_sel_i`, in, DATA_WIDTH/8.
  - `if_wb_ack_o`, out, 1; `if_wb_dat_o`, out, DATA_WIDTH: response to fetch master.
- Data master port:
  - `mem_wb_cyc_i`, `mem_wb_stb_i`, `mem_wb_we_i`, in, 1 each: data-master request.
  - `mem_wb_adr_i`, `mem_wb_dat_i`, `mem_wb_sel_i`, in: same widths as the fetch port.
  - `mem_wb_ack_o`, out, 1; `mem_wb_dat_o`, out, DATA_WIDTH: response to data master.
- Shared bus:
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, out, 1 each.
  - `wb_adr_o`, out, ADDR_WIDTH; `wb_dat_o`, out, DATA_WIDTH; `wb_sel_o`, out, DATA_WIDTH/8.
  - `wb_ack_i`, in, 1; `wb_dat_i`, in, DATA_WIDTH.
- Status:
  - `grant_o`, out, 2: one-hot grant; bit0 is fetch, bit1 is data, 00 means idle.
  - `timeout_o`, out, 1: sticky watchdog flag.

## Operation
**State machine:** IDLE, GRANT_IF, GRANT_MEM. The state register is the only source of grant.

**Grant decision.** In IDLE, at each clock edge:
- Only `if_wb_cyc_i` high → GRANT_IF.
- Only `mem_wb_cyc_i` high → GRANT_MEM.
- Both high → winner chosen by the policy in Configuration.
- Neither high → stay in IDLE.

**While granted.**
- The state holds while the granted master's `cyc` stays high, including across multiple `stb`/`ack` beats.
- When the granted master's `cyc` is low at an edge, the next state is chosen with the IDLE rule applied to the remaining requests. Handoff is direct, with no idle cycle in between.

**Bus multiplexing.** Output muxing is combinational from the state.
- GRANT_x:
  - The granted master's cyc/stb/we/adr/dat/sel drive `wb_*_o`.
  - `wb_ack_i` is routed to the granted master's `ack_o` only.
  - The other master's `ack_o` is 0.
- IDLE: all `wb_*_o` are 0.
- `wb_dat_i` is broadcast to both `*_dat_o` at all times.

**Watchdog.**
- A 16-bit counter increments each cycle the state is not IDLE, `wb_stb_o`=1 and `wb_ack_i`=0.
- It clears on `ack`, on `stb` low, and on any state change.
- When the count reaches TIMEOUT_CYCLES, `timeout_o` sets and stays set until reset. The counter saturates.
- The watchdog does not force release.

**Reset values.** State IDLE, counter 0, `timeout_o`=0, `grant_o`=00, all bus outputs and acks 0. Reset asserted mid-transfer drops `wb_cyc_o` immediately, because it is asynchronous.

## Timing
- **Arbitration latency:** 1 cycle. A master raising `cyc` at edge N sees its signals on the bus from edge N+1 if the bus is free.
- **Ack path:** combinational, with zero added latency.
- **Release:** the granted master dropping `cyc` before edge N frees the bus at N. The other waiting master is on the bus after N.
- **Back-to-back:** a master that keeps `cyc` high holds the bus indefinitely. Masters must drop `cyc` between transactions to allow sharing.
- **`cyc` without `stb`:** a master raising `cyc` with `stb` low is still granted. This is legal Wishbone.
- **Simultaneous events:** release by one master and a new request from the same master at the same edge count as a release, i.e. `cyc` sampled low.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-winner register, reset to "data", is updated on each grant.
  - On a tie, the master that did not win last is granted.
- Not defined: fixed priority, where the data master always wins ties. The last-winner register is absent.

## Test plan
- **Reset:** assert `reset` mid-cycle while GRANT_MEM with `wb_cyc_o`=1 → `wb_cyc_o`=0 and `grant_o`=00 before the next edge; `timeout_o`=0.
- **Single fetch:**
  - Stimulus: `if_wb_cyc_i`/`stb`=1, `adr`=0x8000_0000; slave acks 2 cycles later with `dat`=0x0000_0013.
  - Response: `grant_o`=01 after 1 edge; `if_wb_ack_o` pulses for 1 cycle with `if_wb_dat_o`=0x13; `mem_wb_ack_o` stays 0.
- **Tie:**
  - Stimulus: both `cyc` rise at the same edge, 3 consecutive times; each transfer gets one ack and then drops `cyc`.
  - Response without the macro: D, D, D.
  - Response with `ARB_ROUND_ROBIN_EN`: grant order IF, D, IF.
- **Direct handoff:** data holds `cyc` for 4 cycles while fetch waits → `grant_o` goes 10→01 on the edge `mem_wb_cyc_i` is sampled low, with no 00 cycle.
- **Timeout:** TIMEOUT_CYCLES=8, granted `stb` high, no `ack` → `timeout_o` rises after exactly 8 stalled cycles and stays 1 after `cyc` drops.
- **Ack isolation:** while GRANT_IF, a spurious `wb_ack_i` with `mem_wb_cyc_i`=1 → `mem_wb_ack_o`=0 throughout.
